// File: rtl/tcdm_interconnect_pkg.sv
// Shared types for the TCDM interconnect slice.
// Holds the flush/quiesce sequencer state encoding.
package tcdm_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/credit_counter.sv
// Per-lane in-flight credit counter with request gating.
// pend_q keeps a presented request valid until it is accepted.
module credit_counter #(
  parameter int unsigned MaxOutstanding = 8,
  parameter bit          AxiVldRdy      = 1'b1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                block_i,
  input  logic                req_valid_i,
  input  logic                req_ready_i,
  input  logic                resp_hs_i,
  output logic                net_valid_o,
  output logic                ini_ready_o,
  output logic                pend_o,
  output logic                zero_d_o,
  output logic [CntWidth-1:0] cnt_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                allow;
  logic                inc;

  assign allow       = ((cnt_q < CntMax) & ~block_i) | pend_q;
  assign net_valid_o = req_valid_i & allow;
  assign ini_ready_o = req_ready_i & allow;
  assign inc         = net_valid_o & req_ready_i;
  assign pend_d      = AxiVldRdy & net_valid_o & ~req_ready_i;

  // A response with no credit outstanding saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, resp_hs_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i)
      assert (!(resp_hs_i && cnt_q == '0))
        else $warning("credit_counter: response without credit");
  end

  assign cnt_o    = cnt_q;
  assign pend_o   = pend_q;
  assign zero_d_o = (cnt_d == '0);

endmodule

// File: rtl/variable_latency_credit_ctrl.sv
// Outstanding-request limiter and flush sequencer in front of
// the variable-latency interconnect; handshakes only.
module variable_latency_credit_ctrl
  import tcdm_interconnect_pkg::*;
#(
  parameter int unsigned NumIn          = 32,
  parameter int unsigned MaxOutstanding = 8,
  parameter bit          AxiVldRdy      = 1'b1,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  output logic                           flush_done_o,
  output logic                           idle_o,
  input  logic [NumIn-1:0]               ini_req_valid_i,
  output logic [NumIn-1:0]               ini_req_ready_o,
  output logic [NumIn-1:0]               net_req_valid_o,
  input  logic [NumIn-1:0]               net_req_ready_i,
  input  logic [NumIn-1:0]               net_resp_valid_i,
  output logic [NumIn-1:0]               net_resp_ready_o,
  output logic [NumIn-1:0]               ini_resp_valid_o,
  input  logic [NumIn-1:0]               ini_resp_ready_i,
  output logic [NumIn-1:0][CntWidth-1:0] outstanding_o
);

  flush_state_e state_q, state_d;

  logic [NumIn-1:0] pend;
  logic [NumIn-1:0] zero;
  logic [NumIn-1:0] zero_d;
  logic [NumIn-1:0] resp_hs;
  logic             block;
  logic             drained;
  logic             idle_q;

  assign ini_resp_valid_o = net_resp_valid_i;
  assign net_resp_ready_o = ini_resp_ready_i;
  assign resp_hs          = net_resp_valid_i & ini_resp_ready_i;
  assign block            = (state_q != IDLE);

  for (genvar i = 0; i < NumIn; i++) begin : g_lane
    credit_counter #(
      .MaxOutstanding(MaxOutstanding),
      .AxiVldRdy     (AxiVldRdy),
      .CntWidth      (CntWidth)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .block_i    (block),
      .req_valid_i(ini_req_valid_i[i]),
      .req_ready_i(net_req_ready_i[i]),
      .resp_hs_i  (resp_hs[i]),
      .net_valid_o(net_req_valid_o[i]),
      .ini_ready_o(ini_req_ready_o[i]),
      .pend_o     (pend[i]),
      .zero_d_o   (zero_d[i]),
      .cnt_o      (outstanding_o[i])
    );
    assign zero[i] = (outstanding_o[i] == '0);
  end

  assign drained = (&zero) & ~(|pend);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_i) state_d = DRAIN;
      DRAIN:   if (!flush_i) state_d = IDLE;
               else if (drained) state_d = DONE;
      DONE:    if (!flush_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idle_q  <= &zero_d;
    end
  end

  assign flush_done_o = (state_q == DONE) & flush_i;
  assign idle_o       = idle_q;

endmodule

// File: tb/tb_variable_latency_credit_ctrl.sv
// Scoreboard bench for variable_latency_credit_ctrl.
// Expectations are queued with stimulus and popped around each clock edge.
module tb_variable_latency_credit_ctrl;

  localparam int N  = 4;
  localparam int M  = 2;
  localparam int CW = 2;

  localparam int K_CNT  = 0;
  localparam int K_NV   = 1;
  localparam int K_IR   = 2;
  localparam int K_FD   = 3;
  localparam int K_IDLE = 4;
  localparam int K_RV   = 5;
  localparam int K_RR   = 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic              flush_done_o;
  logic              idle_o;
  logic [N-1:0]      ini_req_valid_i;
  logic [N-1:0]      ini_req_ready_o;
  logic [N-1:0]      net_req_valid_o;
  logic [N-1:0]      net_req_ready_i;
  logic [N-1:0]      net_resp_valid_i;
  logic [N-1:0]      net_resp_ready_o;
  logic [N-1:0]      ini_resp_valid_o;
  logic [N-1:0]      ini_resp_ready_i;
  logic [N-1:0][CW-1:0] outstanding_o;

  always #5 clk_i = ~clk_i;

  variable_latency_credit_ctrl #(
    .NumIn         (N),
    .MaxOutstanding(M),
    .AxiVldRdy     (1'b1)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .flush_done_o    (flush_done_o),
    .idle_o          (idle_o),
    .ini_req_valid_i (ini_req_valid_i),
    .ini_req_ready_o (ini_req_ready_o),
    .net_req_valid_o (net_req_valid_o),
    .net_req_ready_i (net_req_ready_i),
    .net_resp_valid_i(net_resp_valid_i),
    .net_resp_ready_o(net_resp_ready_o),
    .ini_resp_valid_o(ini_resp_valid_o),
    .ini_resp_ready_i(ini_resp_ready_i),
    .outstanding_o   (outstanding_o)
  );

  typedef struct {
    string tag;
    int    kind;
    int    lane;
    int    val;
  } exp_t;

  exp_t now_q[$];
  exp_t nxt_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check_eq(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int observe(int kind, int lane);
    case (kind)
      K_CNT:   return int'(outstanding_o[lane]);
      K_NV:    return int'(net_req_valid_o[lane]);
      K_IR:    return int'(ini_req_ready_o[lane]);
      K_FD:    return int'(flush_done_o);
      K_IDLE:  return int'(idle_o);
      K_RV:    return int'(ini_resp_valid_o[lane]);
      K_RR:    return int'(net_resp_ready_o[lane]);
      default: return -1;
    endcase
  endfunction

  task automatic now_exp(string t, int k, int l, int v);
    now_q.push_back('{t, k, l, v});
  endtask

  task automatic nxt_exp(string t, int k, int l, int v);
    nxt_q.push_back('{t, k, l, v});
  endtask

  task automatic step();
    #1;
    while (now_q.size() > 0) begin
      exp_t e = now_q.pop_front();
      check_eq(e.tag, observe(e.kind, e.lane), e.val);
    end
    @(posedge clk_i);
    #1;
    while (nxt_q.size() > 0) begin
      exp_t e = nxt_q.pop_front();
      check_eq(e.tag, observe(e.kind, e.lane), e.val);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i            = 1'b1;
    flush_i          = 1'b0;
    ini_req_valid_i  = '0;
    net_req_ready_i  = '1;
    net_resp_valid_i = '0;
    ini_resp_ready_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_idle", int'(idle_o), 1);
    check_eq("rst_fd", int'(flush_done_o), 0);
    check_eq("rst_cnt0", int'(outstanding_o[0]), 0);
    rst_i = 1'b0;

    // fill lane 0 up to the limit
    ini_req_valid_i = 4'b0001;
    now_exp("t1_nv_a", K_NV, 0, 1);
    nxt_exp("t1_cnt_a", K_CNT, 0, 1);
    step();
    now_exp("t1_nv_b", K_NV, 0, 1);
    nxt_exp("t1_cnt_b", K_CNT, 0, 2);
    step();
    now_exp("t1_nv_c", K_NV, 0, 0);
    now_exp("t1_ir_c", K_IR, 0, 0);
    now_exp("t1_ir1_c", K_IR, 1, 1);
    nxt_exp("t1_cnt_c", K_CNT, 0, 2);
    step();
    net_resp_valid_i = 4'b0100;
    now_exp("t1_nv_d", K_NV, 0, 0);
    now_exp("t1_rv2", K_RV, 2, 1);
    now_exp("t1_rr2", K_RR, 2, 0);
    nxt_exp("t1_cnt_d", K_CNT, 0, 2);
    nxt_exp("t1_cnt2", K_CNT, 2, 0);
    nxt_exp("t1_cnt3", K_CNT, 3, 0);
    step();

    // response and request together on a full lane
    net_resp_valid_i = 4'b0001;
    ini_resp_ready_i = 4'b0001;
    now_exp("t2_nv_e", K_NV, 0, 0);
    now_exp("t2_rr0", K_RR, 0, 1);
    nxt_exp("t2_cnt_e", K_CNT, 0, 1);
    step();
    now_exp("t2_nv_f", K_NV, 0, 1);
    nxt_exp("t2_cnt_f", K_CNT, 0, 1);
    step();
    net_resp_valid_i = '0;
    now_exp("t2_nv_g", K_NV, 0, 1);
    nxt_exp("t2_cnt_g", K_CNT, 0, 2);
    step();
    now_exp("t2_nv_h", K_NV, 0, 0);
    nxt_exp("t2_cnt_h", K_CNT, 0, 2);
    step();
    ini_req_valid_i = '0;

    // pending request survives flush
    ini_req_valid_i = 4'b0010;
    net_req_ready_i = 4'b1101;
    flush_i         = 1'b1;
    now_exp("t3_nv1_1", K_NV, 1, 1);
    now_exp("t3_ir1_1", K_IR, 1, 0);
    nxt_exp("t3_cnt1_1", K_CNT, 1, 0);
    step();
    ini_req_valid_i = 4'b0110;
    now_exp("t3_nv1_2", K_NV, 1, 1);
    now_exp("t3_nv2_2", K_NV, 2, 0);
    now_exp("t3_ir2_2", K_IR, 2, 0);
    nxt_exp("t3_cnt1_2", K_CNT, 1, 0);
    step();
    now_exp("t3_nv1_3", K_NV, 1, 1);
    step();
    net_req_ready_i = '1;
    now_exp("t3_nv1_4", K_NV, 1, 1);
    now_exp("t3_ir1_4", K_IR, 1, 1);
    now_exp("t3_nv2_4", K_NV, 2, 0);
    nxt_exp("t3_cnt1_4", K_CNT, 1, 1);
    step();
    now_exp("t3_nv1_5", K_NV, 1, 0);
    now_exp("t3_nv2_5", K_NV, 2, 0);
    now_exp("t3_fd_5", K_FD, 0, 0);
    nxt_exp("t3_cnt1_5", K_CNT, 1, 1);
    nxt_exp("t3_cnt0_5", K_CNT, 0, 2);
    step();
    ini_req_valid_i = '0;

    // drain {2,1,0,0} then release
    ini_resp_ready_i = '1;
    net_resp_valid_i = 4'b0001;
    now_exp("t4_fd_1", K_FD, 0, 0);
    nxt_exp("t4_cnt0_1", K_CNT, 0, 1);
    step();
    net_resp_valid_i = '0;
    nxt_exp("t4_idle_2", K_IDLE, 0, 0);
    step();
    net_resp_valid_i = 4'b0010;
    nxt_exp("t4_cnt1_3", K_CNT, 1, 0);
    step();
    net_resp_valid_i = '0;
    now_exp("t4_fd_4", K_FD, 0, 0);
    step();
    net_resp_valid_i = 4'b0001;
    now_exp("t4_fd_5", K_FD, 0, 0);
    nxt_exp("t4_cnt0_5", K_CNT, 0, 0);
    nxt_exp("t4_idle_5", K_IDLE, 0, 1);
    nxt_exp("t4_fd_5n", K_FD, 0, 0);
    step();
    net_resp_valid_i = '0;
    now_exp("t4_fd_6", K_FD, 0, 0);
    nxt_exp("t4_fd_6n", K_FD, 0, 1);
    step();
    ini_req_valid_i = 4'b0100;
    now_exp("t4_fd_7", K_FD, 0, 1);
    now_exp("t4_nv2_7", K_NV, 2, 0);
    nxt_exp("t4_fd_7n", K_FD, 0, 1);
    step();
    flush_i = 1'b0;
    now_exp("t4_fd_8", K_FD, 0, 0);
    now_exp("t4_nv2_8", K_NV, 2, 0);
    nxt_exp("t4_cnt2_8", K_CNT, 2, 0);
    step();
    now_exp("t4_nv2_9", K_NV, 2, 1);
    nxt_exp("t4_cnt2_9", K_CNT, 2, 1);
    nxt_exp("t4_idle_9", K_IDLE, 0, 0);
    step();
    ini_req_valid_i = '0;

    // lane 3 response without credit
    net_resp_valid_i = 4'b1100;
    now_exp("t5_rv3", K_RV, 3, 1);
    nxt_exp("t5_cnt3", K_CNT, 3, 0);
    nxt_exp("t5_cnt2", K_CNT, 2, 0);
    nxt_exp("t5_cnt0", K_CNT, 0, 0);
    nxt_exp("t5_idle", K_IDLE, 0, 1);
    step();
    net_resp_valid_i = '0;

    // asynchronous reset while draining
    ini_req_valid_i = 4'b0001;
    nxt_exp("t6_cnt0_a", K_CNT, 0, 1);
    step();
    nxt_exp("t6_cnt0_b", K_CNT, 0, 2);
    step();
    ini_req_valid_i = '0;
    flush_i         = 1'b1;
    step();
    now_exp("t6_fd_drain", K_FD, 0, 0);
    step();
    #3;
    rst_i = 1'b1;
    #1;
    check_eq("t6_rst_cnt0", int'(outstanding_o[0]), 0);
    check_eq("t6_rst_idle", int'(idle_o), 1);
    check_eq("t6_rst_fd", int'(flush_done_o), 0);
    ini_req_valid_i = 4'b0001;
    #1;
    check_eq("t6_rst_state", int'(net_req_valid_o[0]), 1);
    @(posedge clk_i);
    #1;
    rst_i           = 1'b0;
    flush_i         = 1'b0;
    ini_req_valid_i = '0;
    nxt_exp("t6_idle_end", K_IDLE, 0, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
